// File: rtl/tick_ctrl_pkg.sv
// Shared definitions for the tick controller: state encoding, default
// terminal counts and the ratio-index step.
package tick_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_RELOAD = 2'd3
  } state_e;

  localparam int unsigned LIM0_DEF = 32'h05F5_E0FF;
  localparam int unsigned LIM1_DEF = 32'h02FA_F07F;
  localparam int unsigned LIM2_DEF = 32'h017D_783F;
  localparam int unsigned LIM3_DEF = 32'h00BE_BC1F;

  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    return mode + 2'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: counts while enabled, wraps at the supplied limit and emits a
// registered one-cycle tick on the cycle after the wrap.
module tick_prescaler #(
  parameter int unsigned NR_BITS = 27
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear,
  input  logic               enable,
  input  logic [NR_BITS-1:0] limit,
  output logic [NR_BITS-1:0] count,
  output logic               tc,
  output logic               tick
);

  localparam logic [NR_BITS-1:0] ONE_C  = {{(NR_BITS-1){1'b0}}, 1'b1};
  localparam logic [NR_BITS-1:0] ZERO_C = {NR_BITS{1'b0}};

  logic [NR_BITS-1:0] count_r;
  logic               tick_r;

  assign tc = enable && (count_r == limit);

  // Count register and tick register; clear dominates, hold when disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= ZERO_C;
      tick_r  <= 1'b0;
    end else if (clear) begin
      count_r <= ZERO_C;
      tick_r  <= 1'b0;
    end else if (tc) begin
      count_r <= ZERO_C;
      tick_r  <= 1'b1;
    end else if (enable) begin
      count_r <= count_r + ONE_C;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_r;
      tick_r  <= 1'b0;
    end
  end

  assign count = count_r;
  assign tick  = tick_r;

endmodule

// File: rtl/tick_ctrl.sv
// Run/pause/reload controller around the prescaler; owns ratio selection,
// the tick-pair phase and the every-second-tick strobe.
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned NR_BITS = 27,
  parameter int unsigned LIM0    = LIM0_DEF,
  parameter int unsigned LIM1    = LIM1_DEF,
  parameter int unsigned LIM2    = LIM2_DEF,
  parameter int unsigned LIM3    = LIM3_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  output logic               tick_o,
  output logic               tick2_o,
  output logic               running_o,
  output logic [1:0]         mode_o,
  output logic [NR_BITS-1:0] count_o
);

  localparam logic [NR_BITS-1:0] LIM0_C = NR_BITS'(LIM0);
  localparam logic [NR_BITS-1:0] LIM1_C = NR_BITS'(LIM1);
  localparam logic [NR_BITS-1:0] LIM2_C = NR_BITS'(LIM2);
  localparam logic [NR_BITS-1:0] LIM3_C = NR_BITS'(LIM3);

  state_e             state_r, state_nxt_s;
  logic [1:0]         mode_r, mode_nxt_s;
  logic               phase_r, tick2_r, running_r;
  logic               clear_s, enable_s, phase_clr_s, tc_s;
  logic [NR_BITS-1:0] lim_s;

  // Terminal count for the active ratio.
  always_comb begin
    lim_s = LIM0_C;
    case (mode_r)
      2'd0:    lim_s = LIM0_C;
      2'd1:    lim_s = LIM1_C;
      2'd2:    lim_s = LIM2_C;
      2'd3:    lim_s = LIM3_C;
      default: lim_s = LIM0_C;
    endcase
  end

  // Next state and prescaler control; stop beats start beats mode.
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    clear_s     = 1'b0;
    enable_s    = 1'b0;
    phase_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s = 1'b1;
        if (stop_i) begin
          state_nxt_s = ST_IDLE;
        end else if (start_i) begin
          state_nxt_s = ST_RUN;
        end else if (mode_i) begin
          mode_nxt_s = next_mode(mode_r);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A stop freezes the count even on the terminal-count edge.
        if (stop_i) begin
          state_nxt_s = ST_PAUSE;
        end else if (start_i) begin
          enable_s = 1'b1;
        end else if (mode_i) begin
          state_nxt_s = ST_RELOAD;
          mode_nxt_s  = next_mode(mode_r);
          clear_s     = 1'b1;
        end else begin
          enable_s = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          state_nxt_s = ST_IDLE;
          clear_s     = 1'b1;
          phase_clr_s = 1'b1;
        end else if (start_i) begin
          state_nxt_s = ST_RUN;
        end else if (mode_i) begin
          state_nxt_s = ST_RELOAD;
          mode_nxt_s  = next_mode(mode_r);
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_RELOAD: begin
        state_nxt_s = ST_RUN;
        clear_s     = 1'b1;
        phase_clr_s = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        clear_s     = 1'b1;
        phase_clr_s = 1'b1;
      end
    endcase
  end

  // FSM, ratio, tick-pair phase and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      mode_r    <= 2'd0;
      phase_r   <= 1'b0;
      tick2_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mode_r    <= mode_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      tick2_r   <= tc_s & phase_r;
      if (phase_clr_s) begin
        phase_r <= 1'b0;
      end else if (tc_s) begin
        phase_r <= ~phase_r;
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  tick_prescaler #(
    .NR_BITS (NR_BITS)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (clear_s),
    .enable (enable_s),
    .limit  (lim_s),
    .count  (count_o),
    .tc     (tc_s),
    .tick   (tick_o)
  );

  assign tick2_o   = tick2_r;
  assign running_o = running_r;
  assign mode_o    = mode_r;

endmodule
